// File: rtl/load_store_unit_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
// Holds the RV32I width codes, the FSM state encoding and the store/fault decode.
package load_store_unit_pkg;

  localparam int LSU_LAT_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WAIT   = 2'b10,
    ST_RESP   = 2'b11
  } lsu_state_e;

  // Unsigned widths exist only for loads; stores with those codes are illegal.
  function automatic logic req_fault(input logic write, input logic [2:0] funct3,
                                     input logic [1:0] offset);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = offset[0];
      F3_W:    bad = (offset != 2'b00);
      F3_BU:   bad = write;
      F3_HU:   bad = write | offset[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
    logic [3:0] mask;
    case (funct3)
      F3_B, F3_BU: mask = 4'b0001 << offset;
      F3_H, F3_HU: mask = offset[1] ? 4'b1100 : 4'b0011;
      F3_W:        mask = 4'b1111;
      default:     mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] data;
    case (funct3)
      F3_B:    data = {4{wdata[7:0]}};
      F3_H:    data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-lane alignment: shifts the addressed lane down and sign/zero-extends it.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // NOTE: every output of an always_comb gets a default first, otherwise an unlisted case infers a latch.
  always_comb begin
    shifted = word >> {offset, 3'b000};
    result  = '0;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    result = shifted;
      F3_BU:   result = {24'b0, shifted[7:0]};
      F3_HU:   result = {16'b0, shifted[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between EX/MEM and the data memory macro.
// Latches one request, strobes memory for a single cycle, waits out the latency, responds.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [3:0]            dmem_byte_enable
);

  lsu_state_e            state, state_next;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [2:0]            lat_funct3;
  logic                  lat_write;
  logic                  lat_fault;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_be;
  logic [LSU_LAT_W-1:0]  count;
  logic [31:0]           rdata_q;
  logic [31:0]           load_data;
  logic                  req_bad;

  assign req_bad = req_fault(req_write, req_funct3, req_addr[1:0]);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    resp_valid = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = req_valid & ~reset;
        if (req_valid) state_next = req_bad ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        stall      = 1'b1;
        dmem_write = lat_write;
        dmem_read  = ~lat_write;
        state_next = lat_write ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (count == '0) state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Lane mask and replicated data are registered at latch time so dmem_* never sees req_*.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr   <= '0;
      lat_funct3 <= '0;
      lat_write  <= 1'b0;
      lat_fault  <= 1'b0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      count      <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        lat_addr   <= req_addr;
        lat_funct3 <= req_funct3;
        lat_write  <= req_write;
        lat_fault  <= req_bad;
        lat_wdata  <= lane_data(req_funct3, req_wdata);
        lat_be     <= lane_mask(req_funct3, req_addr[1:0]);
      end
      if (state == ST_ACCESS)
        count <= LSU_LAT_W'(MEM_LATENCY - 1);
      else if (state == ST_WAIT && count != '0)
        count <= count - 1'b1;
      if (state == ST_WAIT && count == '0)
        rdata_q <= load_data;
    end
  end

  lsu_load_align u_align (
    .word   (dmem_rdata),
    .offset (lat_addr[1:0]),
    .funct3 (lat_funct3),
    .result (load_data)
  );

  assign dmem_addr        = {lat_addr[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_wdata       = lat_wdata;
  assign dmem_byte_enable = lat_be;
  assign fault            = (state == ST_RESP) & lat_fault;
  // Stores and faults respond with zero; load data persists otherwise.
  assign resp_rdata       = (state == ST_RESP && (lat_write || lat_fault)) ? '0 : rdata_q;

endmodule
